// File: rtl/nv_ram_rws_param.sv
// nv_ram_rws_param
//   Parametrised 1R1W synchronous-read RAM for FPGA builds. It provides a byte write mask, a
//   selectable read/write collision mode, an optional output register, a read-valid flag, and a
//   power-on sequencer that writes zero to every entry.
//
// Parameters
//   DW        data width in bits, must be a multiple of 8
//   AW        address width
//   DEPTH     number of entries, 1 <= DEPTH <= 2**AW
//   OUT_REG   0: read latency 1; 1: extra output register, read latency 2
//   BYPASS    0: a colliding read returns the old word; 1: it returns the word after the write
//   INIT_ZERO 1: zero all entries after reset; 0: contents undefined, ready at once
//
// Ports
//   clk_i            clock; all state changes on its rising edge
//   rst_i            synchronous reset, active high; overrides every other input
//   ra_i, re_i       read address and read enable
//   dout_o           read data; holds its last value when no read completes
//   dout_vld_o       dout_o carries data from a read accepted 1 or 2 cycles earlier
//   wa_i, we_i       write address and write enable
//   wmask_i          byte write enables; bit k covers di_i[8k+7:8k]
//   di_i             write data
//   init_done_o      high when the RAM accepts reads and writes
//   pwrbus_ram_pd_i  power-bus control; has no function on FPGA
module nv_ram_rws_param #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 7,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned OUT_REG   = 0,
  parameter int unsigned BYPASS    = 0,
  parameter int unsigned INIT_ZERO = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   ra_i,
  input  logic            re_i,
  output logic [DW-1:0]   dout_o,
  output logic            dout_vld_o,
  input  logic [AW-1:0]   wa_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] wmask_i,
  input  logic [DW-1:0]   di_i,
  output logic            init_done_o,
  input  logic [31:0]     pwrbus_ram_pd_i
);

  localparam int unsigned NB = DW / 8;
  // Widened by one bit so that DEPTH == 2**AW is representable.
  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e          state_q;
  logic [AW-1:0]   cnt_q;
  logic [DW-1:0]   rd_q;
  logic            rd_vld_q;

  logic [DW-1:0]   mem [DEPTH];

  logic            ra_in_range;
  logic            wa_in_range;
  logic            collide;
  logic            rd_fire;
  logic [DW-1:0]   rd_word;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [NB-1:0]   wr_be;

  // The power bus has no function on FPGA.
  logic unused_pwrbus;
  assign unused_pwrbus = ^pwrbus_ram_pd_i;

  assign ra_in_range = ({1'b0, ra_i} < DepthW);
  assign wa_in_range = ({1'b0, wa_i} < DepthW);
  assign collide     = re_i && we_i && (ra_i == wa_i);
  assign rd_fire     = (state_q == StReady) && re_i;
  assign init_done_o = (state_q == StReady);

  // A single write port is shared. The init sequencer takes it while it runs, and user writes
  // are ignored during that time.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wa_i;
    wr_data = di_i;
    wr_be   = wmask_i;
    if (!rst_i) begin
      if (state_q == StInit) begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        wr_be   = '1;
      end else if (we_i && wa_in_range) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_be[k]) begin
          mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  // Read word, sampled before this edge's write. In write-first mode, the masked bytes of a
  // colliding write replace the old bytes. Out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    if (ra_in_range) begin
      rd_word = mem[ra_i];
      if ((BYPASS != 0) && collide) begin
        for (int k = 0; k < NB; k++) begin
          if (wmask_i[k]) begin
            rd_word[8*k +: 8] = di_i[8*k +: 8];
          end
        end
      end
    end
  end

  // Init sequencer FSM and the first read stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= (INIT_ZERO != 0) ? StInit : StReady;
      cnt_q    <= '0;
      rd_q     <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      case (state_q)
        StInit: begin
          if (cnt_q == LastIdx) begin
            state_q <= StReady;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        default: state_q <= StReady;
      endcase
      rd_vld_q <= rd_fire;
      if (rd_fire) begin
        rd_q <= rd_word;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DW-1:0] out_q;
    logic          out_vld_q;

    // The second stage loads only when the first stage holds a fresh word. This keeps the data
    // and the valid flag in lockstep, and it keeps dout_o stable between reads.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        out_q     <= '0;
        out_vld_q <= 1'b0;
      end else begin
        out_vld_q <= rd_vld_q;
        if (rd_vld_q) begin
          out_q <= rd_q;
        end
      end
    end

    assign dout_o     = out_q;
    assign dout_vld_o = out_vld_q;
  end else begin : g_no_out_reg
    assign dout_o     = rd_q;
    assign dout_vld_o = rd_vld_q;
  end

endmodule

// File: tb/tb_nv_ram_rws_param.sv
module tb_nv_ram_rws_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        re;
  logic        we;
  logic [6:0]  ra;
  logic [6:0]  wa;
  logic [3:0]  wmask;
  logic [31:0] di;
  logic [31:0] pwr;

  logic [31:0] dout0, dout1;
  logic        vld0, vld1, done0, done1;

  // DUT 0: default configuration. DUT 1: short depth, output register, write-first.
  nv_ram_rws_param #(
    .DW(32), .AW(7), .DEPTH(128), .OUT_REG(0), .BYPASS(0), .INIT_ZERO(1)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .ra_i(ra), .re_i(re), .dout_o(dout0), .dout_vld_o(vld0),
    .wa_i(wa), .we_i(we), .wmask_i(wmask), .di_i(di), .init_done_o(done0),
    .pwrbus_ram_pd_i(pwr)
  );

  nv_ram_rws_param #(
    .DW(32), .AW(7), .DEPTH(100), .OUT_REG(1), .BYPASS(1), .INIT_ZERO(1)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .ra_i(ra), .re_i(re), .dout_o(dout1), .dout_vld_o(vld1),
    .wa_i(wa), .we_i(we), .wmask_i(wmask), .di_i(di), .init_done_o(done1),
    .pwrbus_ram_pd_i(pwr)
  );

  logic [31:0] dout_a [2];
  logic        vld_a  [2];
  logic        done_a [2];
  assign dout_a[0] = dout0;
  assign dout_a[1] = dout1;
  assign vld_a[0]  = vld0;
  assign vld_a[1]  = vld1;
  assign done_a[0] = done0;
  assign done_a[1] = done1;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: an array of words per DUT, a count of init cycles remaining, and a
  // one-slot delay line for the latency-2 configuration.
  logic [31:0] mm [2][128];
  int          left [2];
  logic        pv [2];
  logic [31:0] pd [2];
  logic [31:0] exp_dout [2];
  logic        exp_vld [2];

  function automatic int dep(int d);
    return (d == 0) ? 128 : 100;
  endfunction

  function automatic int lat(int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      logic        v;
      logic [31:0] r;
      v = 1'b0;
      r = '0;
      if (rst) begin
        left[d]     = dep(d);
        pv[d]       = 1'b0;
        pd[d]       = '0;
        exp_vld[d]  = 1'b0;
        exp_dout[d] = '0;
      end else begin
        if (left[d] > 0) begin
          mm[d][dep(d) - left[d]] = '0;
          left[d]--;
        end else begin
          if (re) begin
            v = 1'b1;
            if (int'(ra) < dep(d)) begin
              r = mm[d][ra];
              if (d == 1 && we && wa == ra) r = merge(r, di, wmask);
            end
          end
          if (we && int'(wa) < dep(d)) mm[d][wa] = merge(mm[d][wa], di, wmask);
        end
        if (lat(d) == 1) begin
          exp_vld[d] = v;
          if (v) exp_dout[d] = r;
        end else begin
          exp_vld[d] = pv[d];
          if (pv[d]) exp_dout[d] = pd[d];
          pv[d] = v;
          pd[d] = r;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    re = 1'b0; we = 1'b0; ra = '0; wa = '0; wmask = '0; di = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    cycle();
    cycle();
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if (dout_a[d] !== 32'h0 || vld_a[d] !== 1'b0 || done_a[d] !== 1'b0)
        $display("FAIL reset dut%0d: dout=%h vld=%b done=%b, want 0/0/0",
                 d, dout_a[d], vld_a[d], done_a[d]);
      else n_pass++;
    end
  endtask

  // Deassert reset and record the cycle on which init_done first rises.
  task automatic run_init(input int pulse_cycles);
    int rise [2];
    rise[0] = -1;
    rise[1] = -1;
    rst = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      if (n <= pulse_cycles) begin
        re = 1'($urandom); we = 1'($urandom);
        ra = 7'($urandom); wa = 7'($urandom);
        di = $urandom; wmask = 4'hF;
      end else idle_inputs();
      cycle();
      for (int d = 0; d < 2; d++) if (done_a[d] === 1'b1 && rise[d] < 0) rise[d] = n;
      if (rise[0] > 0 && rise[1] > 0) break;
    end
    idle_inputs();
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if (rise[d] != dep(d))
        $display("FAIL init_len dut%0d: init_done rose after %0d cycles, want %0d",
                 d, rise[d], dep(d));
      else n_pass++;
    end
  endtask

  task automatic test_init();
    run_init(0);
    re = 1'b1; ra = 7'd5;
    cycle();
    re = 1'b0;
    cycle();
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if (dout_a[d] !== 32'h0) $display("FAIL init_read5 dut%0d: got %h want 0", d, dout_a[d]);
      else n_pass++;
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; wa = 7'd3; di = 32'hDEADBEEF; wmask = 4'hF;
    cycle();
    idle_inputs();
    re = 1'b1; ra = 7'd3;
    cycle();
    re = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if (vld_a[d] !== (lat(d) == 1))
        $display("FAIL vld_lat1 dut%0d: got %b want %b", d, vld_a[d], lat(d) == 1);
      else n_pass++;
    end
    cycle();
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if (vld_a[d] !== (lat(d) == 2) || dout_a[d] !== 32'hDEADBEEF)
        $display("FAIL write_read dut%0d: vld=%b dout=%h want %b/deadbeef",
                 d, vld_a[d], dout_a[d], lat(d) == 2);
      else n_pass++;
    end
  endtask

  task automatic test_masked();
    we = 1'b1; wa = 7'd3; di = 32'h11223344; wmask = 4'b0101;
    cycle();
    idle_inputs();
    re = 1'b1; ra = 7'd3;
    cycle();
    re = 1'b0;
    cycle();
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if (dout_a[d] !== 32'hDE22BE44)
        $display("FAIL masked dut%0d: got %h want de22be44", d, dout_a[d]);
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    logic [31:0] want;
    we = 1'b1; wa = 7'd9; di = 32'hAAAA0000; wmask = 4'hF;
    cycle();
    re = 1'b1; ra = 7'd9; we = 1'b1; wa = 7'd9; di = 32'h12345678; wmask = 4'hF;
    cycle();
    idle_inputs();
    cycle();
    for (int d = 0; d < 2; d++) begin
      want = (d == 0) ? 32'hAAAA0000 : 32'h12345678;
      n_total++;
      if (dout_a[d] !== want) $display("FAIL collision dut%0d: got %h want %h", d, dout_a[d], want);
      else n_pass++;
    end
    re = 1'b1; ra = 7'd9;
    cycle();
    re = 1'b0;
    cycle();
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if (dout_a[d] !== 32'h12345678)
        $display("FAIL after_collision dut%0d: got %h want 12345678", d, dout_a[d]);
      else n_pass++;
    end
  endtask

  // Read 0..127 on consecutive cycles and check each word at its latency.
  task automatic sweep_read(input bit use_zero);
    logic [31:0] want;
    for (int c = 0; c < 130; c++) begin
      if (c < 128) begin re = 1'b1; ra = 7'(c); end
      else re = 1'b0;
      cycle();
      for (int d = 0; d < 2; d++) begin
        int j;
        j = c - (lat(d) - 1);
        if (j >= 0 && j < 128) begin
          want = (use_zero || j >= dep(d)) ? 32'h0 : 32'(3 * j);
          n_total++;
          if (vld_a[d] !== 1'b1 || dout_a[d] !== want)
            $display("FAIL sweep dut%0d idx%0d: vld=%b dout=%h want 1/%h",
                     d, j, vld_a[d], dout_a[d], want);
          else n_pass++;
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_init_abort();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int n = 0; n < 50; n++) begin
      re = 1'($urandom); we = 1'($urandom);
      ra = 7'($urandom); wa = 7'($urandom); di = $urandom; wmask = 4'hF;
      cycle();
      for (int d = 0; d < 2; d++) begin
        n_total++;
        if (vld_a[d] !== 1'b0 || done_a[d] !== 1'b0)
          $display("FAIL init_ignore dut%0d cyc%0d: vld=%b done=%b want 0/0",
                   d, n, vld_a[d], done_a[d]);
        else n_pass++;
      end
    end
    rst = 1'b1;
    idle_inputs();
    cycle();
    run_init(90);
    sweep_read(1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 128; i++) begin
      we = 1'b1; wa = 7'(i); di = 32'(3 * i); wmask = 4'hF;
      cycle();
    end
    idle_inputs();
    sweep_read(1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      re = 1'($urandom);
      we = 1'($urandom);
      ra = 7'($urandom_range(0, 127));
      wa = ($urandom_range(0, 3) == 0) ? ra : 7'($urandom_range(0, 127));
      di = $urandom;
      wmask = 4'($urandom_range(0, 15));
      cycle();
      for (int d = 0; d < 2; d++) begin
        n_total++;
        if (vld_a[d] !== exp_vld[d] || dout_a[d] !== exp_dout[d] || done_a[d] !== 1'b1)
          $display("FAIL random dut%0d cyc%0d: vld=%b dout=%h done=%b want %b/%h/1",
                   d, n, vld_a[d], dout_a[d], done_a[d], exp_vld[d], exp_dout[d]);
        else n_pass++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    pwr = '0;
    for (int d = 0; d < 2; d++) begin
      left[d] = 0; pv[d] = 1'b0; pd[d] = '0; exp_dout[d] = '0; exp_vld[d] = 1'b0;
    end
    test_reset();
    test_init();
    test_write_read();
    test_masked();
    test_collision();
    test_back_to_back();
    test_random();
    test_init_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
